// File: rtl/niosqs_irq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : niosqs_irq_pkg
// Purpose  : Shared register map constants for the NIOS-QS interrupt controller.
// Revision : 1.0 - initial release
// ============================================================================
package niosqs_irq_pkg;

  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_MASK    = 3'd1;
  localparam logic [2:0] ADDR_EDGE    = 3'd2;
  localparam logic [2:0] ADDR_RAW     = 3'd3;
  localparam logic [2:0] ADDR_VECTOR  = 3'd4;
  localparam logic [2:0] ADDR_SWSET   = 3'd5;

  localparam int VEC_VALID_BIT   = 15;
  localparam int DEFAULT_NUM_IRQ = 8;

endpackage
`default_nettype wire

// File: rtl/niosqs_irq_prio_enc.sv
`default_nettype none
// ============================================================================
// Module   : niosqs_irq_prio_enc
// Purpose  : Combinational lowest-index-first priority encoder.
// Revision : 1.0 - initial release
// ============================================================================
module niosqs_irq_prio_enc #(
  parameter int N = 8,
  parameter int W = 4
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [W-1:0] index
);

  // Scan downward so the lowest set bit is the last assignment.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        index = W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/niosqs_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : niosqs_irq_ctrl
// Purpose  : Avalon-MM interrupt controller with pending/mask/edge registers
//            and a vector register. Optional macro NIOSQS_IRQ_CTRL_EDGE_EN
//            adds a per-line edge/level selection register.
// Revision : 1.0 - initial release
// ============================================================================
module niosqs_irq_ctrl
  import niosqs_irq_pkg::*;
#(
  parameter int NUM_IRQ = DEFAULT_NUM_IRQ,
  parameter int VEC_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  output logic               irq
);

  logic [NUM_IRQ-1:0] r_irq_q;
  logic [NUM_IRQ-1:0] r_pend;
  logic [NUM_IRQ-1:0] r_mask;
  logic [NUM_IRQ-1:0] w_edge;
  logic [NUM_IRQ-1:0] w_set_evt;
  logic [NUM_IRQ-1:0] w_to_edge;
  logic [NUM_IRQ-1:0] w_pending;
  logic [NUM_IRQ-1:0] w_active;
  logic [NUM_IRQ-1:0] w_set;
  logic [NUM_IRQ-1:0] w_clr;
  logic [NUM_IRQ-1:0] w_pend_nxt;
  logic [NUM_IRQ-1:0] w_wd;
  logic [15:0]        w_rd;
  logic               w_wr;
  logic               w_we_pend;
  logic               w_we_mask;
  logic               w_we_swset;
  logic               w_vld;
  logic [VEC_W-1:0]   w_idx;
  logic               w_unused;

  assign w_wr       = chipselect & ~write_n;
  assign w_we_pend  = w_wr && (address == ADDR_PENDING);
  assign w_we_mask  = w_wr && (address == ADDR_MASK);
  assign w_we_swset = w_wr && (address == ADDR_SWSET);
  assign w_wd       = writedata[NUM_IRQ-1:0];
  assign w_unused   = ^writedata;

`ifdef NIOSQS_IRQ_CTRL_EDGE_EN
  logic [NUM_IRQ-1:0] r_irq_qq;
  logic [NUM_IRQ-1:0] r_edge;
  logic               w_we_edge;

  assign w_we_edge = w_wr && (address == ADDR_EDGE);
  assign w_edge    = r_edge;
  assign w_set_evt = r_irq_q & ~r_irq_qq;
  // Lines moving from level to edge capture their visible pending state.
  assign w_to_edge = w_we_edge ? (w_wd & ~r_edge) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_qq <= '0;
      r_edge   <= '1;
    end else begin
      r_irq_qq <= r_irq_q;
      if (w_we_edge) r_edge <= w_wd;
    end
  end
`else
  // Without a delayed copy every line latches while irq_q is high; a single
  // cycle pulse sets PENDING on the same edge an edge detector would.
  assign w_edge    = '1;
  assign w_set_evt = r_irq_q;
  assign w_to_edge = '0;
`endif

  // In level mode r_pend holds only the software-set part.
  assign w_pending  = r_pend | (~w_edge & r_irq_q);
  assign w_active   = w_pending & r_mask;
  assign w_set      = (w_edge & w_set_evt) | (w_we_swset ? w_wd : '0);
  assign w_clr      = w_we_pend ? w_wd : '0;
  assign w_pend_nxt = w_set | (w_to_edge & w_pending) | (r_pend & ~w_clr);

  niosqs_irq_prio_enc #(
    .N (NUM_IRQ),
    .W (VEC_W)
  ) u_prio_enc (
    .req   (w_active),
    .valid (w_vld),
    .index (w_idx)
  );

  always_comb begin
    w_rd = '0;
    case (address)
      ADDR_PENDING: w_rd[NUM_IRQ-1:0] = w_pending;
      ADDR_MASK:    w_rd[NUM_IRQ-1:0] = r_mask;
      ADDR_EDGE:    w_rd[NUM_IRQ-1:0] = w_edge;
      ADDR_RAW:     w_rd[NUM_IRQ-1:0] = r_irq_q;
      ADDR_VECTOR: begin
        w_rd[VEC_VALID_BIT] = w_vld;
        w_rd[VEC_W-1:0]     = w_idx;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_q  <= '0;
      r_pend   <= '0;
      r_mask   <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      r_irq_q  <= irq_in;
      r_pend   <= w_pend_nxt;
      if (w_we_mask) r_mask <= w_wd;
      readdata <= w_rd;
      irq      <= |w_active;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_niosqs_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_niosqs_irq_ctrl
// Purpose  : Directed self-checking bench for niosqs_irq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_niosqs_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  irq_in;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  niosqs_irq_ctrl #(
    .NUM_IRQ (8),
    .VEC_W   (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [15:0] exp);
    address = a;
    tick();
    check_val(tag, readdata, exp);
  endtask

  task automatic pulse(input logic [7:0] m);
    irq_in = m;
    tick();
    irq_in = '0;
    tick();
    tick();
  endtask

  initial begin
    reset      = 1'b1;
    irq_in     = '0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    tick();
    tick();
    reset = 1'b0;

    check_val("reset_irq", {15'd0, irq}, 16'h0000);
    check_val("reset_readdata", readdata, 16'h0000);
    rd_chk("reset_pending", 3'd0, 16'h0000);
    rd_chk("reset_mask", 3'd1, 16'h0000);
    rd_chk("reset_edge", 3'd2, 16'h00FF);
    rd_chk("reset_vector", 3'd4, 16'h0000);

    // Single pulse on the timer line, irq three edges after the pulse starts.
    wr(3'd1, 16'h0001);
    irq_in = 8'h01;
    tick();
    irq_in = '0;
    tick();
    check_val("timer_irq_early", {15'd0, irq}, 16'h0000);
    tick();
    check_val("timer_irq", {15'd0, irq}, 16'h0001);
    rd_chk("timer_pending", 3'd0, 16'h0001);
    wr(3'd0, 16'h0001);
    check_val("w1c_irq_still", {15'd0, irq}, 16'h0001);
    tick();
    check_val("w1c_irq_clear", {15'd0, irq}, 16'h0000);
    rd_chk("w1c_pending", 3'd0, 16'h0000);

    // Vector priority.
    wr(3'd1, 16'h00FF);
    pulse(8'h24);
    rd_chk("vector_2", 3'd4, 16'h8002);
    rd_chk("pending_25", 3'd0, 16'h0024);
    wr(3'd0, 16'h0004);
    rd_chk("vector_5", 3'd4, 16'h8005);
    wr(3'd0, 16'h0020);
    rd_chk("vector_none", 3'd4, 16'h0000);

    // Set on line 3 and W1C of bit 3 on the same edge.
    irq_in = 8'h08;
    tick();
    irq_in = '0;
    wr(3'd0, 16'h0008);
    rd_chk("set_wins", 3'd0, 16'h0008);
    wr(3'd0, 16'h0008);
    rd_chk("set_wins_clear", 3'd0, 16'h0000);

    // RAW shows irq_q.
    irq_in = 8'h30;
    tick();
    rd_chk("raw", 3'd3, 16'h0030);
    irq_in = '0;
    tick();
    tick();
    wr(3'd0, 16'h00FF);

    // Software set with masking.
    wr(3'd1, 16'h0000);
    wr(3'd5, 16'h0080);
    tick();
    check_val("swset_irq_masked", {15'd0, irq}, 16'h0000);
    rd_chk("swset_pending", 3'd0, 16'h0080);
    rd_chk("swset_reads0", 3'd5, 16'h0000);
    wr(3'd1, 16'h0080);
    tick();
    check_val("unmask_irq", {15'd0, irq}, 16'h0001);
    rd_chk("reserved6", 3'd6, 16'h0000);
    rd_chk("reserved7", 3'd7, 16'h0000);
    wr(3'd6, 16'hFFFF);
    rd_chk("reserved_wr_ignored", 3'd1, 16'h0080);
    wr(3'd0, 16'h0080);
    wr(3'd1, 16'h0000);

`ifdef NIOSQS_IRQ_CTRL_EDGE_EN
    // Level mode on line 0.
    wr(3'd2, 16'hFFFE);
    rd_chk("edge_reg", 3'd2, 16'h00FE);
    wr(3'd1, 16'h0001);
    irq_in = 8'h01;
    tick();
    tick();
    rd_chk("level_pending", 3'd0, 16'h0001);
    wr(3'd0, 16'h0001);
    rd_chk("level_w1c_noeffect", 3'd0, 16'h0001);
    irq_in = '0;
    rd_chk("level_drop_1", 3'd0, 16'h0001);
    rd_chk("level_drop_2", 3'd0, 16'h0000);
    // Level to edge switch keeps a pending level.
    irq_in = 8'h01;
    tick();
    tick();
    wr(3'd2, 16'hFFFF);
    irq_in = '0;
    tick();
    tick();
    rd_chk("switch_keeps", 3'd0, 16'h0001);
    wr(3'd0, 16'h0001);
    rd_chk("switch_cleared", 3'd0, 16'h0000);
    wr(3'd1, 16'h0000);
`else
    wr(3'd2, 16'h0000);
    rd_chk("edge_wr_ignored", 3'd2, 16'h00FF);
`endif

    // Reset overriding a write and incoming lines.
    wr(3'd5, 16'h000F);
    wr(3'd1, 16'h00FF);
    tick();
    check_val("pre_reset_irq", {15'd0, irq}, 16'h0001);
    address    = 3'd5;
    writedata  = 16'h00F0;
    chipselect = 1'b1;
    write_n    = 1'b0;
    irq_in     = 8'hFF;
    reset      = 1'b1;
    tick();
    reset      = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    irq_in     = '0;
    check_val("mid_reset_irq", {15'd0, irq}, 16'h0000);
    check_val("mid_reset_readdata", readdata, 16'h0000);
    rd_chk("mid_reset_pending", 3'd0, 16'h0000);
    rd_chk("mid_reset_mask", 3'd1, 16'h0000);
    rd_chk("mid_reset_edge", 3'd2, 16'h00FF);
    rd_chk("mid_reset_raw", 3'd3, 16'h0000);
    rd_chk("mid_reset_vector", 3'd4, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/niosqs_irq_ctrl.md
NIOSQS_IRQ_CTRL -- requirements
Module: niosqs_irq_ctrl

Interface
REQ-001 Parameter NUM_IRQ, default 8, number of interrupt source lines (legal 1..16).
REQ-002 Parameter VEC_W, default 4, width of the vector index field (must satisfy 2**VEC_W >= NUM_IRQ).
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 irq_in  input  NUM_IRQ  source lines, same clock domain as clk; bit 0 carries the timer irq.
REQ-006 address  input  3  Avalon-MM word address.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe.
REQ-009 writedata  input  16  write data.
REQ-010 readdata  output  16  registered read data.
REQ-011 irq  output  1  registered combined interrupt to the CPU.

Function
REQ-012 irq_in shall pass through one register stage (irq_q); all detection shall use irq_q and its delayed copy irq_qq.
REQ-013 Register map: 0 PENDING (R, W1C); 1 MASK (R/W, 1 = enabled); 2 EDGE (R/W, 1 = edge mode); 3 RAW (R, irq_q); 4 VECTOR (R, {valid at bit 15, index at bits VEC_W-1:0}); 5 SWSET (W, write-1 sets PENDING bits; reads 0); 6-7 reserved, reads 0, writes ignored.
REQ-014 Only bits NUM_IRQ-1:0 of each register shall be implemented; unimplemented bits read 0.
REQ-015 Write strobe = chipselect && ~write_n && address match; writes take effect on the next clock edge.
REQ-016 readdata shall be a one-cycle-latency registered mux of the addressed register, updated every cycle regardless of chipselect.
REQ-017 Edge mode line n: PENDING[n] sets on irq_q[n] & ~irq_qq[n] and stays set until cleared by W1C.
REQ-018 Level mode line n: PENDING[n] = irq_q[n] | sw_pend[n]; W1C clears only sw_pend[n].
REQ-019 A set (edge or SWSET) and a W1C on the same bit in the same cycle: set wins, bit remains 1.
REQ-020 VECTOR: index = lowest n with PENDING[n] & MASK[n]; valid = 1 if any such n exists; index = 0 when valid = 0.
REQ-021 irq shall be registered: irq <= |(PENDING & MASK), one cycle after PENDING/MASK change.
REQ-022 Masking shall not affect PENDING; unmasking a pending line asserts irq on the following cycle.
REQ-023 Writing EDGE shall not alter PENDING; a line switched from level to edge keeps its current PENDING value until cleared.

Reset
REQ-024 On reset: PENDING, sw_pend, MASK, irq_q, irq_qq, readdata, irq = 0; EDGE = all ones.
REQ-025 Reset asserted mid-operation shall override any same-cycle write or detected edge.

Configuration
REQ-026 Macro NIOSQS_IRQ_CTRL_EDGE_EN: when defined, the EDGE register and edge detection per REQ-017 shall be implemented.
REQ-027 Without NIOSQS_IRQ_CTRL_EDGE_EN: all lines shall be edge mode, EDGE shall read all ones, writes to address 2 shall be ignored, and irq_qq and the EDGE flops shall not be instantiated.

Structure
REQ-028 Shared package niosqs_irq_pkg shall hold the register address constants (PENDING, MASK, EDGE, RAW, VECTOR, SWSET), the VECTOR valid bit position, and the default NUM_IRQ.
REQ-029 One sub-module, niosqs_irq_prio_enc (combinational lowest-index priority encoder, outputs valid and index), shall be used for the VECTOR logic.

Verification
REQ-030 Reset, then pulse irq_in[0] for 1 cycle with MASK=0x0001 -> PENDING reads 0x0001, irq = 1 three cycles after the pulse; write PENDING=0x0001 -> irq = 0 two cycles later.
REQ-031 Pulse irq_in[5] and irq_in[2] together, MASK=0x00FF -> VECTOR reads 0x8002; W1C 0x0004 -> VECTOR reads 0x8005.
REQ-032 Edge pulse on line 3 in the same cycle as W1C 0x0008 -> PENDING[3] stays 1.
REQ-033 With EDGE_EN defined, EDGE=0xFFFE, hold irq_in[0] high -> PENDING[0] = 1 and W1C has no effect; drop irq_in[0] -> PENDING[0] = 0 two cycles later.
REQ-034 MASK=0, write SWSET=0x0080 -> PENDING = 0x0080, irq = 0; write MASK=0x0080 -> irq = 1 the next cycle; read address 6 -> 0x0000.
REQ-035 Assert reset while lines are pending and a write is in progress -> all registers and irq read their reset values on the next cycle.
